// File: rtl/bp_nonsynth_stall_histogram.sv
// bp_nonsynth_stall_histogram
// Bins the per-cycle stall-reason stream from the core profiler into one
// saturating counter per reason, plus instret and unknown bins, over fixed
// windows of enabled cycles. At each window end the bins are snapshotted and
// streamed out over a valid/ready dump port, one entry per beat.
// Optional feature: define BP_STALL_HIST_PRINT_EN to echo every transferred
// beat to the simulation log.
module bp_nonsynth_stall_histogram #(
  parameter int num_reasons_p = 21,
  parameter int cnt_width_p   = 32,
  parameter int window_p      = 1024,
  localparam int num_entries_lp = num_reasons_p + 2,
  localparam int idx_width_lp   = (num_entries_lp > 1) ? $clog2(num_entries_lp) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_li,
  input  logic                    en_i,
  input  logic                    instret_i,
  input  logic                    stall_v_i,
  input  logic [4:0]              stall_reason_i,
  input  logic                    flush_i,
  input  logic                    dump_ready_i,
  output logic                    dump_v_o,
  output logic [idx_width_lp-1:0] dump_idx_o,
  output logic [cnt_width_p-1:0]  dump_count_o,
  output logic                    dump_last_o,
  output logic                    overflow_o,
  output logic [7:0]              dropped_o
);

  localparam int win_width_lp = (window_p > 1) ? $clog2(window_p) : 1;
  localparam logic [cnt_width_p-1:0]  cnt_max_lp     = '1;
  localparam logic [idx_width_lp-1:0] instret_idx_lp = idx_width_lp'(num_reasons_p);
  localparam logic [idx_width_lp-1:0] unknown_idx_lp = idx_width_lp'(num_reasons_p + 1);
  localparam logic [idx_width_lp-1:0] last_idx_lp    = idx_width_lp'(num_entries_lp - 1);
  localparam logic [win_width_lp-1:0] win_last_lp    = win_width_lp'(window_p - 1);

  typedef enum logic {
    e_idle,
    e_dump
  } state_e;

  state_e state_r, state_n;

  logic [cnt_width_p-1:0]  live_r [num_entries_lp];
  logic [cnt_width_p-1:0]  live_n [num_entries_lp];
  logic [cnt_width_p-1:0]  snap_r [num_entries_lp];
  logic [win_width_lp-1:0] win_r;
  logic [idx_width_lp-1:0] idx_r;
  logic [idx_width_lp-1:0] sel;
  logic [7:0]              dropped_r;
  logic                    overflow_r;
  logic                    sat_hit;
  logic                    win_end;
  logic                    beat_xfer;
  logic                    last_xfer;
  logic                    load_snap;
  logic                    clear_live;
  logic                    drop;

  assign dump_v_o     = (state_r == e_dump);
  assign dump_idx_o   = idx_r;
  assign dump_count_o = snap_r[idx_r];
  assign dump_last_o  = dump_v_o && (idx_r == last_idx_lp);
  assign overflow_o   = overflow_r;
  assign dropped_o    = dropped_r;

  // Pick exactly one bin per cycle: instret beats a stall, bad reasons go to unknown
  always_comb begin
    sel = unknown_idx_lp;
    if (instret_i)
      sel = instret_idx_lp;
    else if (stall_v_i && (32'(stall_reason_i) < 32'(num_reasons_p)))
      sel = idx_width_lp'(stall_reason_i);
  end

  // Saturating increment of the selected bin; flag any attempt past the top
  always_comb begin
    sat_hit = 1'b0;
    for (int i = 0; i < num_entries_lp; i++) begin
      live_n[i] = live_r[i];
      if (en_i && (sel == idx_width_lp'(i))) begin
        if (live_r[i] == cnt_max_lp)
          sat_hit = 1'b1;
        else
          live_n[i] = live_r[i] + cnt_width_p'(1);
      end
    end
  end

  // Window end, dump handshake and snapshot/drop decisions
  always_comb begin
    win_end    = en_i && (win_r == win_last_lp);
    beat_xfer  = dump_v_o && dump_ready_i;
    last_xfer  = beat_xfer && dump_last_o;
    load_snap  = ((state_r == e_idle) && (win_end || flush_i)) || (last_xfer && win_end);
    clear_live = win_end || ((state_r == e_idle) && flush_i);
    drop       = (state_r == e_dump) && win_end && !last_xfer;
  end

  // Next-state logic: a window ending on the final beat chains straight into a new dump
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle: if (load_snap) state_n = e_dump;
      e_dump: begin
        if (load_snap)      state_n = e_dump;
        else if (last_xfer) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) state_r <= e_idle;
    else           state_r <= state_n;
  end

  // Dump index restarts on a fresh snapshot and advances only on a transfer
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li)      idx_r <= '0;
    else if (load_snap) idx_r <= '0;
    else if (beat_xfer) idx_r <= last_xfer ? '0 : idx_r + idx_width_lp'(1);
  end

  // Window counter counts enabled cycles and restarts at every window end
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li)       win_r <= '0;
    else if (clear_live) win_r <= '0;
    else if (en_i)       win_r <= win_r + win_width_lp'(1);
  end

  // Live bins accumulate and clear at window end; snapshot captures the final cycle too
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      for (int i = 0; i < num_entries_lp; i++) begin
        live_r[i] <= '0;
        snap_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < num_entries_lp; i++) begin
        live_r[i] <= clear_live ? '0 : live_n[i];
        if (load_snap) snap_r[i] <= live_n[i];
      end
    end
  end

  // Sticky saturation flag and saturating count of windows lost while dumping
  always_ff @(posedge clk_i or negedge reset_li) begin
    if (!reset_li) begin
      overflow_r <= 1'b0;
      dropped_r  <= '0;
    end else begin
      if (sat_hit) overflow_r <= 1'b1;
      if (drop && (dropped_r != 8'hff)) dropped_r <= dropped_r + 8'd1;
    end
  end

`ifdef BP_STALL_HIST_PRINT_EN
  // Echo each transferred beat; the final beat also reports the status flags
  always @(posedge clk_i) begin
    if (reset_li && beat_xfer) begin
      $display("stall_hist idx=%0d count=%0d", dump_idx_o, dump_count_o);
      if (dump_last_o)
        $display("stall_hist overflow=%0d dropped=%0d", overflow_o, dropped_o);
    end
  end
`else
`endif

endmodule

// File: tb/tb_bp_nonsynth_stall_histogram.sv
// tb_bp_nonsynth_stall_histogram
// Directed bench for the stall histogram. A main instance (window 8, 32-bit
// bins) is checked beat by beat against a scoreboard fed by a classification
// model; a second instance (window 16, 3-bit bins) exercises saturation.
module tb_bp_nonsynth_stall_histogram;

  localparam int numEntries = 23;

  typedef struct {
    int   idx;
    int   cnt;
    logic last;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        reset_li = 1'b0;
  logic        en = 1'b0;
  logic        instret = 1'b0;
  logic        stallV = 1'b0;
  logic [4:0]  stallReason = '0;
  logic        flush = 1'b0;
  logic        dumpReady = 1'b1;
  logic        satMode = 1'b0;
  logic        mainEn;
  logic        satEn;

  logic        dumpV, dumpLast, overflow;
  logic [4:0]  dumpIdx;
  logic [31:0] dumpCount;
  logic [7:0]  dropped;

  logic        satV, satLast, satOverflow;
  logic [4:0]  satIdx;
  logic [2:0]  satCount;
  logic [7:0]  satDropped;

  int    vecCount = 0;
  int    errCount = 0;
  int    modelCnt [numEntries];
  beat_t sbQueue [$];
  beat_t expBeat;

  assign mainEn = en && !satMode;
  assign satEn  = en && satMode;

  bp_nonsynth_stall_histogram #(.num_reasons_p(21), .cnt_width_p(32), .window_p(8)) dut (
    .clk_i(clk_i), .reset_li(reset_li), .en_i(mainEn), .instret_i(instret),
    .stall_v_i(stallV), .stall_reason_i(stallReason), .flush_i(flush),
    .dump_ready_i(dumpReady), .dump_v_o(dumpV), .dump_idx_o(dumpIdx),
    .dump_count_o(dumpCount), .dump_last_o(dumpLast), .overflow_o(overflow),
    .dropped_o(dropped)
  );

  bp_nonsynth_stall_histogram #(.num_reasons_p(21), .cnt_width_p(3), .window_p(16)) dut_sat (
    .clk_i(clk_i), .reset_li(reset_li), .en_i(satEn), .instret_i(instret),
    .stall_v_i(stallV), .stall_reason_i(stallReason), .flush_i(1'b0),
    .dump_ready_i(1'b1), .dump_v_o(satV), .dump_idx_o(satIdx),
    .dump_count_o(satCount), .dump_last_o(satLast), .overflow_o(satOverflow),
    .dropped_o(satDropped)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  // One comparison: count it, and report tag/observed/expected on a miss
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, update the bin model, and step to just past the edge
  task automatic applyStimulus(input logic e, input logic ir, input logic sv,
                               input logic [4:0] r, input logic f);
    int sel;
    en = e; instret = ir; stallV = sv; stallReason = r; flush = f;
    if (e && !satMode) begin
      if (ir)                  sel = 21;
      else if (sv && (r < 21)) sel = int'(r);
      else                     sel = 22;
      modelCnt[sel]++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < numEntries; i++) modelCnt[i] = 0;
  endtask

  // A window ended in the idle state: the model's bins become the next expected dump
  task automatic pushSnapshot();
    for (int i = 0; i < numEntries; i++)
      sbQueue.push_back('{idx: i, cnt: modelCnt[i], last: (i == numEntries - 1)});
    clearModel();
  endtask

  // Drop reset asynchronously mid-cycle, check the outputs fall at once, then release
  task automatic doReset();
    reset_li = 1'b0;
    #1;
    checkOutput("rst_dump_v", 32'(dumpV), 32'd0);
    checkOutput("rst_dump_last", 32'(dumpLast), 32'd0);
    checkOutput("rst_dump_idx", 32'(dumpIdx), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_dropped", 32'(dropped), 32'd0);
    sbQueue.delete();
    clearModel();
    en = 1'b0; instret = 1'b0; stallV = 1'b0; flush = 1'b0; dumpReady = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_li = 1'b1;
  endtask

  // Idle cycles until every expected beat has been seen, bounded
  task automatic waitDrain(input string tag, input int maxCycles);
    int n = 0;
    while (((sbQueue.size() != 0) || dumpV) && (n < maxCycles)) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      n++;
    end
    checkOutput(tag, 32'((sbQueue.size() == 0) && !dumpV), 32'd1);
  endtask

  // Scoreboard: every transferred beat must match the head of the expected queue
  always @(negedge clk_i) begin
    if (reset_li && dumpV && dumpReady) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_beat_idx", 32'(dumpIdx), 32'hffff_ffff);
      end else begin
        expBeat = sbQueue.pop_front();
        checkOutput("beat_idx", 32'(dumpIdx), 32'(expBeat.idx));
        checkOutput("beat_count", dumpCount, 32'(expBeat.cnt));
        checkOutput("beat_last", 32'(dumpLast), 32'(expBeat.last));
      end
    end
  end

  // Hard stop if the sequence ever wedges
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    clearModel();
    repeat (2) @(posedge clk_i);
    #1;
    reset_li = 1'b1;

    // Reset mid-stream, then a window of enabled idle cycles lands in unknown
    $display("[TB] reset then idle window");
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
    doReset();
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    pushSnapshot();
    waitDrain("drain_idle", 60);

    // Single reason for a full window, with 1-cycle dump latency and ignored flushes
    $display("[TB] single reason");
    doReset();
    repeat (7) applyStimulus(1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
    checkOutput("single_v_before_end", 32'(dumpV), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
    pushSnapshot();
    checkOutput("single_v_after_end", 32'(dumpV), 32'd1);
    checkOutput("single_first_idx", 32'(dumpIdx), 32'd0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    checkOutput("flush_in_dump_no_drop", 32'(dropped), 32'd0);
    waitDrain("drain_single", 60);

    // Instret priority over stall, in-range reason, out-of-range reason, idle
    $display("[TB] mixed priority");
    doReset();
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b1, 5'd9, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b1, 5'd25, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    pushSnapshot();
    waitDrain("drain_mixed", 60);

    // Backpressure: beat 0 holds while a whole window expires and is dropped
    $display("[TB] backpressure and drop");
    doReset();
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
    pushSnapshot();
    dumpReady = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 5'd3, 1'b0);
      if (c == 8) clearModel();
      checkOutput("hold_v", 32'(dumpV), 32'd1);
      checkOutput("hold_idx", 32'(dumpIdx), 32'd0);
      checkOutput("hold_count", dumpCount, 32'd8);
    end
    checkOutput("dropped_one", 32'(dropped), 32'd1);
    dumpReady = 1'b1;
    waitDrain("drain_backpressure", 60);

    // Window expiring on the last beat chains a new dump with no gap
    $display("[TB] expiry on last beat");
    doReset();
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
    pushSnapshot();
    dumpReady = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 2) dumpReady = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1, 5'd6, 1'b0);
      if ((c == 8) || (c == 16)) clearModel();
    end
    pushSnapshot();
    checkOutput("chain_v", 32'(dumpV), 32'd1);
    checkOutput("chain_idx", 32'(dumpIdx), 32'd0);
    checkOutput("chain_dropped", 32'(dropped), 32'd2);
    waitDrain("drain_chain", 60);

    // Saturation on the narrow instance; the flag stays set into the next window
    $display("[TB] saturation");
    satMode = 1'b1;
    doReset();
    checkOutput("sat_rst_overflow", 32'(satOverflow), 32'd0);
    for (int c = 1; c <= 16; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
      if (c == 7) checkOutput("sat_ovf_at_max", 32'(satOverflow), 32'd0);
      if (c == 8) checkOutput("sat_ovf_past_max", 32'(satOverflow), 32'd1);
    end
    checkOutput("sat_v", 32'(satV), 32'd1);
    checkOutput("sat_idx", 32'(satIdx), 32'd0);
    checkOutput("sat_count", 32'(satCount), 32'd7);
    repeat (16) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("sat_ovf_sticky", 32'(satOverflow), 32'd1);
    checkOutput("main_ovf_clear", 32'(overflow), 32'd0);
    satMode = 1'b0;

    // Flush ends a short window; async reset in mid-dump kills it immediately
    $display("[TB] flush and async reset");
    doReset();
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 5'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    pushSnapshot();
    checkOutput("flush_v", 32'(dumpV), 32'd1);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("flush_beat5_idx", 32'(dumpIdx), 32'd5);
    doReset();
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("post_reset_idle", 32'(dumpV), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/bp_nonsynth_stall_histogram.md
Name: bp_nonsynth_stall_histogram

Overview:
- Downstream consumer of the per-cycle stall-reason stream from the core profiler.
- Accumulates one counter per stall reason, plus instruction-retired and unknown counters, over fixed windows of enabled cycles.
- At each window boundary it snapshots the counters and streams them out over a valid/ready dump interface to a trace writer or host.
- Nonsynthesizable bench infrastructure. It lives next to the profiler in bp_top/test/common.

Parameters:
- num_reasons_p, 21, number of stall-reason encodings (0..num_reasons_p-1).
- cnt_width_p, 32, width of every histogram counter.
- window_p, 1024, enabled cycles per sampling window; must be >= 2.
- num_entries_lp, num_reasons_p+2, derived; entry num_reasons_p = instret, entry num_reasons_p+1 = unknown.
- idx_width_lp, `BSG_SAFE_CLOG2(num_entries_lp), derived.

Ports:
- clk_i  in  1  clock.
- reset_li  in  1  reset, asynchronous, active-low.
- en_i  in  1  count enable (core not frozen, not in reset).
- instret_i  in  1  instruction committed this cycle.
- stall_v_i  in  1  stall reason valid this cycle.
- stall_reason_i  in  5  encoded stall reason.
- flush_i  in  1  force an early window end.
- dump_ready_i  in  1  consumer accepts current beat.
- dump_v_o  out  1  dump beat valid.
- dump_idx_o  out  idx_width_lp  entry index of current beat.
- dump_count_o  out  cnt_width_p  snapshot count of that entry.
- dump_last_o  out  1  current beat is entry num_entries_lp-1.
- overflow_o  out  1  sticky: some counter saturated.
- dropped_o  out  8  saturating count of windows lost to backpressure.

Behaviour:
- Reset (reset_li=0, asynchronous): all live counters, snapshot, window counter, overflow_o, dropped_o and dump_idx_o go to 0. dump_v_o=0, dump_last_o=0, FSM=IDLE.
- Classification, only when en_i=1, exactly one entry per cycle:
  - instret_i=1 → instret entry. instret_i wins over stall_v_i.
  - else stall_v_i=1 and stall_reason_i<num_reasons_p → that reason's entry.
  - else → unknown entry. This covers stall_v_i=0 and out-of-range reasons.
- en_i=0: no counting, window counter holds.
- Counters saturate at 2^cnt_width_p-1. Any increment attempted at saturation sets overflow_o. overflow_o clears only on reset.
- Window counter increments per enabled cycle. The terminal cycle is (window count == window_p-1 and en_i), or (flush_i in IDLE).
- On a terminal edge in IDLE:
  - Snapshot receives live counts including the terminal cycle's increment.
  - Live counters and window counter clear.
  - FSM goes to DUMP.
  - dump_v_o=1, dump_idx_o=0 on the following cycle (1-cycle latency).
- DUMP state:
  - Beat transfers when dump_v_o & dump_ready_i. dump_idx_o then increments next cycle.
  - While dump_v_o & ~dump_ready_i, idx/count/last are held stable.
  - After the transfer with dump_last_o=1: dump_v_o=0 next cycle, FSM back to IDLE.
  - Full dump with ready tied high = num_entries_lp consecutive beats.
- Window expiry while in DUMP:
  - Live counters and window counter clear as normal.
  - Snapshot is NOT overwritten; dropped_o increments (saturates at 255).
  - flush_i in DUMP is ignored and does not count as a drop.
- Expiry on the same cycle as the last beat transfer: treated as IDLE-terminal. New snapshot loads, and DUMP restarts at idx 0 the next cycle with no gap.
- Counting continues unaffected during DUMP.

Optional Feature:
- Macro BP_STALL_HIST_PRINT_EN.
- Defined: every transferred beat issues $display("stall_hist idx=%0d count=%0d", dump_idx_o, dump_count_o). The last beat also prints overflow_o and dropped_o.
- Undefined: no simulation output; the port behaviour is identical in both cases.

Test Plan:
All scenarios use window_p=8 and num_reasons_p=21 (23 entries, idx_width_lp=5) unless noted.
1. Reset: hold reset_li=0 mid-stream, then release → dump_v_o=0, overflow_o=0, dropped_o=0. First dump after 8 enabled idle cycles shows idx22=8 and all other entries 0.
2. Single reason: en_i=1, stall_v_i=1, reason=4 for 8 cycles, ready=1 → dump_v_o rises 1 cycle after the 8th edge, 23 consecutive beats, idx4=8, all others 0, dump_last_o only at idx22.
3. Mixed with priority: 3 cycles instret_i=1 with stall_v_i=1, then 2 cycles reason=9, then 2 cycles reason=25, then 1 cycle idle → idx21=3, idx9=2, idx22=3.
4. Backpressure and drop: dump_ready_i=0 for 10 cycles after dump starts, with en_i=1 → beat idx0 held stable, dropped_o=1. Releasing ready completes the original snapshot unchanged.
5. Saturation: cnt_width_p=3, window_p=16, reason=0 for 16 cycles → idx0=7, overflow_o=1 and remains 1 after the next window.
6. Flush and async reset: flush_i after 3 cycles of reason=2 → dump has idx2=3. Driving reset_li=0 during beat 5 → dump_v_o=0 immediately without waiting for a clock edge, FSM back to IDLE.
